// File: rtl/immediate_pkg.sv
// Shared encodings for the immediate extend stage: select codes and skid-buffer states.
package immediate_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [2:0] IMM_Z = 3'b101;

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StTwo   = 2'b10
  } buf_state_e;

endpackage

// File: rtl/immediate_extend_core.sv
// Combinational immediate extractor: maps (instruction, select) to an XLEN-wide immediate.
module immediate_extend_core
  import immediate_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instruction,
  input  logic [2:0]      immediate_select,
  output logic [XLEN-1:0] immediate,
  output logic            type_error
);

  logic        sign;
  logic [31:0] imm32;

  assign sign = instruction[31];

  always_comb begin
    imm32      = '0;
    type_error = 1'b0;
    case (immediate_select)
      IMM_I: imm32 = {{20{sign}}, instruction[31:20]};
      IMM_S: imm32 = {{20{sign}}, instruction[31:25], instruction[11:7]};
      IMM_B: imm32 = {{19{sign}}, sign, instruction[7], instruction[30:25],
                      instruction[11:8], 1'b0};
      IMM_J: imm32 = {{11{sign}}, sign, instruction[19:12], instruction[20],
                      instruction[30:21], 1'b0};
      IMM_U: imm32 = {instruction[31:12], 12'b0};
      IMM_Z: imm32 = {27'b0, instruction[19:15]};
      default: type_error = 1'b1;
    endcase
  end

  // Z and reserved selects leave bit 31 clear, so a plain sign extension is correct for all.
  if (XLEN > 32) begin : g_wide
    assign immediate = {{(XLEN-32){imm32[31]}}, imm32};
  end else begin : g_narrow
    assign immediate = imm32;
  end

endmodule

// File: rtl/immediate_extend_stage.sv
// Registered immediate extend stage: input-side extension into a 2-entry skid buffer.
module immediate_extend_stage
  import immediate_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instruction,
  input  logic [2:0]             in_immediate_select,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_immediate,
  output logic                   out_type_error,
  output logic [COUNT_WIDTH-1:0] error_count
);

  localparam int unsigned SlotW = XLEN + 1;

  buf_state_e             state_q, state_d;
  logic [SlotW-1:0]       main_q, main_d, skid_q, skid_d;
  logic [SlotW-1:0]       ext_slot;
  logic [XLEN-1:0]        ext_imm;
  logic                   ext_err;
  logic                   accept, pop;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  immediate_extend_core #(
    .XLEN(XLEN)
  ) u_core (
    .instruction     (in_instruction),
    .immediate_select(in_immediate_select),
    .immediate       (ext_imm),
    .type_error      (ext_err)
  );

  assign ext_slot = {ext_err, ext_imm};
  assign accept   = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StOne;
          main_d  = ext_slot;
        end
      end
      StOne: begin
        if (accept && pop) begin
          main_d = ext_slot;
        end else if (accept) begin
          state_d = StTwo;
          skid_d  = ext_slot;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (pop) begin
          state_d = StOne;
          main_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Slot contents are don't-care once the state is empty, so only the state is forced.
    if (flush) begin
      state_d = StEmpty;
    end
  end

  // Handshake outputs depend on state only, never on out_ready.
  always_comb begin
    in_ready  = (state_q != StTwo);
    out_valid = (state_q != StEmpty);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  always_comb begin
    count_d = count_q;
    if (pop && main_q[XLEN] && (count_q != {COUNT_WIDTH{1'b1}})) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out_immediate  = main_q[XLEN-1:0];
  assign out_type_error = main_q[XLEN];
  assign error_count    = count_q;

endmodule

// File: tb/tb_immediate_extend_stage.sv
// Self-checking bench: scoreboard on a 32-bit instance plus direct checks on a 64-bit instance.
module tb_immediate_extend_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instruction = '0;
  logic [2:0]  in_immediate_select = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_immediate;
  logic        out_type_error;
  logic [7:0]  error_count;

  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [31:0] w_instruction = '0;
  logic [2:0]  w_select = '0;
  logic        w_out_valid;
  logic [63:0] w_immediate;
  logic        w_type_error;
  logic [7:0]  w_error_count;
  logic        w_flush = 1'b0;
  logic        w_out_ready = 1'b1;

  int n_checks = 0;
  int n_err    = 0;
  int exp_err  = 0;
  logic [64:0] sb[$];

  always #5 clock = ~clock;

  immediate_extend_stage #(
    .XLEN(32),
    .COUNT_WIDTH(8)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .flush              (flush),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_instruction     (in_instruction),
    .in_immediate_select(in_immediate_select),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_immediate      (out_immediate),
    .out_type_error     (out_type_error),
    .error_count        (error_count)
  );

  immediate_extend_stage #(
    .XLEN(64),
    .COUNT_WIDTH(8)
  ) dut_wide (
    .clock              (clock),
    .reset              (reset),
    .flush              (w_flush),
    .in_valid           (w_in_valid),
    .in_ready           (w_in_ready),
    .in_instruction     (w_instruction),
    .in_immediate_select(w_select),
    .out_valid          (w_out_valid),
    .out_ready          (w_out_ready),
    .out_immediate      (w_immediate),
    .out_type_error     (w_type_error),
    .error_count        (w_error_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference built from arithmetic shifts and masks: {type_error, 64-bit immediate}.
  function automatic logic [64:0] model(input logic [31:0] ins, input logic [2:0] sel);
    logic signed [63:0] s;
    logic [63:0] r;
    logic e;
    s = $signed({{32{ins[31]}}, ins});
    e = 1'b0;
    case (sel)
      3'd0: r = 64'(s >>> 20);
      3'd1: r = (64'(s >>> 20) & ~64'h1f) | 64'(ins[11:7]);
      3'd2: r = (64'(s >>> 19) & ~64'hfff) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5)
                | (64'(ins[11:8]) << 1);
      3'd3: r = (64'(s >>> 11) & ~64'hfffff) | 64'(ins & 32'h000f_f000)
                | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
      3'd4: r = 64'(s) & ~64'hfff;
      3'd5: r = 64'(ins[19:15]);
      default: begin
        r = '0;
        e = 1'b1;
      end
    endcase
    return {e, r};
  endfunction

  // Scoreboard: output side popped before input side pushed, mirroring one clock edge.
  always @(negedge clock) begin
    logic [64:0] e;
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_out", 64'(out_valid), 64'(0));
        end else begin
          e = sb.pop_front();
          check("sb_imm", 64'(out_immediate), 64'(e[31:0]));
          check("sb_type_error", 64'(out_type_error), 64'(e[64]));
          if (e[64] && exp_err < 255) exp_err++;
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(model(in_instruction, in_immediate_select));
    end
  end

  task automatic send(input logic [31:0] ins, input logic [2:0] sel);
    int n;
    in_valid = 1'b1;
    in_instruction = ins;
    in_immediate_select = sel;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) check("send_timeout", 64'(in_ready), 64'(1));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic run_wide(input string tag, input logic [31:0] ins, input logic [2:0] sel,
                          input logic [63:0] exp);
    w_in_valid = 1'b1;
    w_instruction = ins;
    w_select = sel;
    @(posedge clock);
    #1;
    w_in_valid = 1'b0;
    check({tag, "_valid"}, 64'(w_out_valid), 64'(1));
    check(tag, w_immediate, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_in_ready_during", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_immediate", 64'(out_immediate), 64'(0));
    check("rst_type_error", 64'(out_type_error), 64'(0));
    check("rst_error_count", 64'(error_count), 64'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_in_ready_after", 64'(in_ready), 64'(1));

    run_wide("x64_u", 32'h8000_00B7, 3'b100, 64'hFFFF_FFFF_8000_0000);
    run_wide("x64_j", 32'h8000_006F, 3'b011, 64'hFFFF_FFFF_FFF0_0000);
    run_wide("x64_z", 32'hFFFF_FFF3, 3'b101, 64'h0000_0000_0000_001F);
    idle(1);

    out_ready = 1'b1;
    send(32'hFFF0_0093, 3'b000);
    check("lat_i_valid", 64'(out_valid), 64'(1));
    check("lat_i_imm", 64'(out_immediate), 64'hFFFF_FFFF);
    check("lat_i_err", 64'(out_type_error), 64'(0));
    send(32'hFE00_0EE3, 3'b010);
    check("b_imm", 64'(out_immediate), 64'hFFFF_FFFC);
    send(32'h1234_50B7, 3'b100);
    check("u_imm", 64'(out_immediate), 64'h1234_5000);
    send(32'h000F_8073, 3'b101);
    check("z_imm", 64'(out_immediate), 64'h0000_001F);
    send(32'h8A5F_3C23, 3'b001);
    idle(2);

    // Back-pressure: A and B fill the buffer, C waits for space.
    out_ready = 1'b0;
    send(32'h0010_0093, 3'b000);
    check("bp_ready_one", 64'(in_ready), 64'(1));
    send(32'hFE00_0EE3, 3'b010);
    check("bp_ready_two", 64'(in_ready), 64'(0));
    in_valid = 1'b1;
    in_instruction = 32'hABCD_E037;
    in_immediate_select = 3'b100;
    @(negedge clock);
    check("bp_hold_ready", 64'(in_ready), 64'(0));
    check("bp_hold_imm", 64'(out_immediate), 64'h0000_0001);
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check($sformatf("bp_stream_%0d", k), 64'(out_valid), 64'(1));
      @(posedge clock);
      #1;
      if (k == 1) in_valid = 1'b0;
    end
    check("bp_drained", 64'(out_valid), 64'(0));

    send(32'h1234_5678, 3'b111);
    check("rsv_imm", 64'(out_immediate), 64'(0));
    check("rsv_err", 64'(out_type_error), 64'(1));
    idle(2);
    check("rsv_count_one", 64'(error_count), 64'(1));

    // Flush in TWO with a simultaneous offer: nothing may survive.
    out_ready = 1'b0;
    send(32'h0020_0093, 3'b000);
    send(32'h0030_0093, 3'b000);
    in_valid = 1'b1;
    in_instruction = 32'h7FF0_0093;
    in_immediate_select = 3'b000;
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_two_valid", 64'(out_valid), 64'(0));
    check("flush_two_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    idle(3);
    check("flush_two_quiet", 64'(out_valid), 64'(0));

    // Flush while delivering an error entry: the delivery still counts.
    out_ready = 1'b0;
    send(32'h0000_0000, 3'b110);
    out_ready = 1'b1;
    flush = 1'b1;
    in_valid = 1'b1;
    in_instruction = 32'h0040_0093;
    in_immediate_select = 3'b000;
    @(posedge clock);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_pop_valid", 64'(out_valid), 64'(0));
    check("flush_pop_count", 64'(error_count), 64'(2));
    idle(2);
    check("flush_pop_quiet", 64'(out_valid), 64'(0));

    for (int i = 0; i < 300; i++) send(32'(i * 32'h0101_0007), (i % 2 == 0) ? 3'b111 : 3'b110);
    idle(3);
    check("sat_model", 64'(error_count), 64'(exp_err));
    check("sat_count", 64'(error_count), 64'(255));

    out_ready = 1'b0;
    send(32'hFFF0_0093, 3'b000);
    #3;
    check("pre_reset_valid", 64'(out_valid), 64'(1));
    reset = 1'b1;
    #1;
    sb.delete();
    exp_err = 0;
    check("arst_valid", 64'(out_valid), 64'(0));
    check("arst_imm", 64'(out_immediate), 64'(0));
    check("arst_ready", 64'(in_ready), 64'(1));
    check("arst_count", 64'(error_count), 64'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    idle(2);
    check("arst_no_survivor", 64'(out_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
